// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-FF sync, per-channel glitch filter, Gray phase decode, up/down count.
// Define QUAD_DIV4_EN for x1 decode (count only on the 3<->0 phase crossing); default is x4 decode.
module quad_decoder #(
  parameter int CNT_BITS  = 8,
  parameter int FILT_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic                clr,
  output logic [CNT_BITS-1:0] pos,
  output logic                step,
  output logic                dir,
  output logic                err
);

  localparam logic [FILT_LOG2-1:0] FCNT_MAX = '1;

  logic [1:0] pin_in;
  logic [1:0] filt_vec_q;
  logic [1:0] filt_vec_d;

  assign pin_in = {enc_a, enc_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic                 s1_q;
      logic                 s2_q;
      logic                 filt_q;
      logic                 filt_d;
      logic [FILT_LOG2-1:0] fcnt_q;
      logic [FILT_LOG2-1:0] fcnt_d;

      // Synchronizer flops run free; reset only seeds the filter from their output.
      always_ff @(posedge clk) begin
        s1_q <= pin_in[gi];
        s2_q <= s1_q;
      end

      always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        if (rst) begin
          filt_d = s2_q;
        end else if (s2_q != filt_q) begin
          if (fcnt_q == FCNT_MAX) begin
            filt_d = s2_q;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        filt_q <= filt_d;
        fcnt_q <= fcnt_d;
      end

      assign filt_vec_q[gi] = filt_q;
      assign filt_vec_d[gi] = filt_d;
    end
  endgenerate

  logic [1:0]          phase;
  logic [1:0]          phase_seed;
  logic [1:0]          delta;
  logic [1:0]          prev_phase_q, prev_phase_d;
  logic [CNT_BITS-1:0] pos_q, pos_d;
  logic                step_q, step_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic                count_up;
  logic                count_dn;

  assign phase      = {filt_vec_q[1], filt_vec_q[1] ^ filt_vec_q[0]};
  assign phase_seed = {filt_vec_d[1], filt_vec_d[1] ^ filt_vec_d[0]};
  assign delta      = phase - prev_phase_q;

`ifdef QUAD_DIV4_EN
  assign count_up = (prev_phase_q == 2'd3) && (phase == 2'd0);
  assign count_dn = (prev_phase_q == 2'd0) && (phase == 2'd3);
`else
  assign count_up = (delta == 2'd1);
  assign count_dn = (delta == 2'd3);
`endif

  always_comb begin
    pos_d        = pos_q;
    step_d       = 1'b0;
    dir_d        = dir_q;
    err_d        = err_q;
    prev_phase_d = phase;
    if (rst) begin
      // Track the seeded filter level so leaving reset never produces a count.
      pos_d        = '0;
      dir_d        = 1'b0;
      err_d        = 1'b0;
      prev_phase_d = phase_seed;
    end else begin
      if (count_up) begin
        pos_d  = pos_q + 1'b1;
        dir_d  = 1'b1;
        step_d = 1'b1;
      end else if (count_dn) begin
        pos_d  = pos_q - 1'b1;
        dir_d  = 1'b0;
        step_d = 1'b1;
      end
      if (delta == 2'd2) begin
        err_d = 1'b1;
      end
      if (clr) begin
        pos_d = '0;
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    prev_phase_q <= prev_phase_d;
    pos_q        <= pos_d;
    step_q       <= step_d;
    dir_q        <= dir_d;
    err_q        <= err_d;
  end

  assign pos  = pos_q;
  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: directed pin sequences push expected step events,
// a negedge monitor pops and compares them whenever step is seen.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] pos;
  logic       step;
  logic       dir;
  logic       err;

  quad_decoder #(.CNT_BITS(8), .FILT_LOG2(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .clr   (clr),
    .pos   (pos),
    .step  (step),
    .dir   (dir),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] pos;
    logic       dir;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) begin
      passed++;
      $display("check %-12s got %0h expected %0h ok", name, act, req);
    end else begin
      $display("FAIL %-12s got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle with step high must match the oldest expected event.
  always @(negedge clk) begin
    if (step) begin
      if (exp_q.size() == 0) begin
        check("extra_step", {24'd0, pos}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_pos", {24'd0, pos}, {24'd0, e.pos});
        check("step_dir", {31'd0, dir}, {31'd0, e.dir});
        if (e.cyc >= 0) check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic b, input bit push,
                       input logic [7:0] epos, input logic edir);
    exp_t e;
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    if (push) begin
      e.pos = epos;
      e.dir = edir;
      e.cyc = -1;
      exp_q.push_back(e);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic expect_quiet(input string name, input logic [7:0] epos, input logic eerr);
    check({name, "_pos"}, {24'd0, pos}, {24'd0, epos});
    check({name, "_err"}, {31'd0, err}, {31'd0, eerr});
    check({name, "_pend"}, exp_q.size(), 0);
  endtask

  initial begin
    int c0;
    do_reset(1'b0, 1'b0);
    check("rst_pos", {24'd0, pos}, 32'd0);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_dir", {31'd0, dir}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

`ifdef QUAD_DIV4_EN
    // x1: one full forward cycle counts once, the reverse cycle undoes it.
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    expect_quiet("x1_fwd", 8'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_quiet("x1_rev", 8'd0, 1'b0);
`else
    // Forward cycle: four counts up.
    drive(1'b0, 1'b1, 1'b1, 8'd1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'd3, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 8'd4, 1'b1);
    expect_quiet("fwd", 8'd4, 1'b0);

    // One step down from zero wraps.
    do_reset(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
    expect_quiet("down", 8'hFF, 1'b0);
    check("down_dir", {31'd0, dir}, 32'd0);

    // Short glitch is dropped, then a held change counts with fixed latency.
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    enc_a = 1'b1;
    repeat (10) @(negedge clk);
    enc_a = 1'b0;
    repeat (40) @(negedge clk);
    expect_quiet("glitch", 8'd0, 1'b0);
    c0 = cyc + 1;
    enc_b = 1'b1;
    begin
      exp_t e;
      e.pos = 8'd1;
      e.dir = 1'b1;
      e.cyc = c0 + 18;
      exp_q.push_back(e);
    end
    repeat (40) @(negedge clk);
    expect_quiet("lat", 8'd1, 1'b0);

    // Count to 5 ending at 11, reset there, then continue from 11.
    do_reset(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'd1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'd4, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'd5, 1'b1);
    expect_quiet("five", 8'd5, 1'b0);
    do_reset(1'b1, 1'b1);
    repeat (30) @(negedge clk);
    expect_quiet("midrst", 8'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'd1, 1'b1);
    expect_quiet("after_rst", 8'd1, 1'b0);
`endif

    // Both channels switch together: illegal jump, no count; clr clears err.
    do_reset(1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_quiet("jump", 8'd0, 1'b1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    expect_quiet("clr", 8'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
